// File: rtl/pwm_robot.sv
// Four-channel PWM generator fed by the robot I/O PWM register word.
// Duty bytes are double-buffered and take effect only at a period boundary.
module pwm_robot #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [31:0] pwm_duty,
    output logic [3:0]  pwm_out,
    output logic        period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_r;
    logic [7:0]       cnt_r;
    logic [3:0][7:0]  shadow_r;
    logic             tick_s;
    logic             load_s;
    logic [3:0][7:0]  eff_s;
    logic [3:0]       cmp_s;

    // Period bookkeeping and per-channel compare against the effective duty.
    always_comb begin
        tick_s = (pre_r == PRE_MAX);
        load_s = en & (pre_r == PRE_ZERO) & (cnt_r == 8'd0);
        eff_s  = shadow_r;
        cmp_s  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            // The load clock compares against the incoming byte so the new duty governs its own period.
            if (load_s) begin
                eff_s[i] = pwm_duty[8*i +: 8];
            end else begin
                eff_s[i] = shadow_r[i];
            end
            cmp_s[i] = (cnt_r < eff_s[i]);
        end
    end

    // Counters, duty shadow and registered outputs; disable parks everything but the shadow.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pre_r        <= PRE_ZERO;
            cnt_r        <= 8'd0;
            shadow_r     <= '0;
            pwm_out      <= 4'b0000;
            period_start <= 1'b0;
        end else if (!en) begin
            pre_r        <= PRE_ZERO;
            cnt_r        <= 8'd0;
            pwm_out      <= 4'b0000;
            period_start <= 1'b0;
        end else begin
            if (tick_s) begin
                pre_r <= PRE_ZERO;
                cnt_r <= cnt_r + 8'd1;
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end
            if (load_s) begin
                shadow_r <= pwm_duty;
            end
            pwm_out      <= cmp_s;
            period_start <= load_s;
        end
    end

endmodule
